// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry full_adder.
// The optional FULL_ADDER_OVF_EN build adds a registered signed-overflow output.
package full_adder_pkg;

    localparam int FA_WIDTH_DEFAULT = 1;
    localparam int FA_WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder cell; the ripple chain in full_adder is
// built from copies of this cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {ripout, c} = a + b + ripin, one cycle later.
// Define FULL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ripin,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             ripout
`ifdef FULL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
            $error("full_adder: WIDTH must be in 1..64");
        end
    endgenerate

    // k[i] is the carry into bit i; k[0] is the external carry-in.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum;

    assign k[0] = ripin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            fa_cell u_cell (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (k[i]),
                .s    (sum[i]),
                .cout (k[i+1])
            );
        end
    endgenerate

    // Handshake: valid-only, no ready. Operands are taken on every rising edge
    // with in_valid=1; out_valid is high for exactly the cycle after each such
    // edge. Idle cycles leave the result registers untouched, so undriven
    // operands never reach c/ripout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            ripout    <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c      <= sum;
                ripout <= k[WIDTH];
`ifdef FULL_ADDER_OVF_EN
                ovf    <= k[WIDTH] ^ k[WIDTH-1];
`endif
            end
        end
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1 and WIDTH=4 sharing one clock and reset.
// Honours FULL_ADDER_OVF_EN to also check the overflow output.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v1_in, a1, b1, r1, ov1, c1, k1, ovf1;
    logic       v4_in, r4, ov4, k4, ovf4;
    logic [3:0] a4, b4, c4;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1_in),
        .a         (a1),
        .b         (b1),
        .ripin     (r1),
        .out_valid (ov1),
        .c         (c1),
        .ripout    (k1)
`ifdef FULL_ADDER_OVF_EN
       ,.ovf       (ovf1)
`endif
    );

    full_adder #(.WIDTH(4)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4_in),
        .a         (a4),
        .b         (b4),
        .ripin     (r4),
        .out_valid (ov4),
        .c         (c4),
        .ripout    (k4)
`ifdef FULL_ADDER_OVF_EN
       ,.ovf       (ovf4)
`endif
    );

`ifndef FULL_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Entries are {valid, ovf, ripout, c}; idle entries carry the held result.
    logic [3:0] exp1_q[$];
    logic [6:0] exp4_q[$];
    logic [2:0] hold1 = '0;
    logic [5:0] hold4 = '0;

    typedef struct {
        logic       v1;
        logic       a1, b1, r1;
        logic [1:0] e1;
        logic       v4;
        logic [3:0] a4, b4;
        logic       r4;
        logic [4:0] e4;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ovf_w1(input logic a, input logic b, input logic r);
        logic carry;
        carry = (a & b) | (r & (a ^ b));
        return carry ^ r;
    endfunction

    function automatic logic ovf_w4(input logic [3:0] a, input logic [3:0] b, input logic r);
        logic [4:0] s;
        logic [3:0] lo;
        s  = {1'b0, a} + {1'b0, b} + {4'b0, r};
        lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, r};
        return s[4] ^ lo[3];
    endfunction

    // Drive both instances for one cycle and queue what should appear next cycle.
    task automatic drive(input logic v1, input logic a1v, input logic b1v, input logic r1v,
                         input logic [1:0] e1, input logic v4, input logic [3:0] a4v,
                         input logic [3:0] b4v, input logic r4v, input logic [4:0] e4);
        @(negedge clk);
        v1_in = v1; a1 = a1v; b1 = b1v; r1 = r1v;
        v4_in = v4; a4 = a4v; b4 = b4v; r4 = r4v;
        if (v1) hold1 = {ovf_w1(a1v, b1v, r1v), e1};
        if (v4) hold4 = {ovf_w4(a4v, b4v, r4v), e4};
        exp1_q.push_back({v1, hold1});
        exp4_q.push_back({v4, hold4});
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'b00,
              1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 5'h00);
    endtask

    // Scoreboard: one result per driven cycle, sampled just after the capture edge.
    always @(posedge clk) begin
        logic [3:0] e1;
        logic [6:0] e4;
        #1;
        if (exp1_q.size() > 0) begin
            e1 = exp1_q.pop_front();
            check("w1_valid", {7'b0, ov1}, {7'b0, e1[3]});
            check("w1_sum", {6'b0, k1, c1}, {6'b0, e1[1:0]});
`ifdef FULL_ADDER_OVF_EN
            check("w1_ovf", {7'b0, ovf1}, {7'b0, e1[2]});
`endif
        end
        if (exp4_q.size() > 0) begin
            e4 = exp4_q.pop_front();
            check("w4_valid", {7'b0, ov4}, {7'b0, e4[6]});
            check("w4_sum", {3'b0, k4, c4}, {3'b0, e4[4:0]});
`ifdef FULL_ADDER_OVF_EN
            check("w4_ovf", {7'b0, ovf4}, {7'b0, e4[5]});
`endif
        end
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'hF, 4'h1, 1'b0, 5'h10};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 4'h7, 4'h8, 1'b1, 5'h10};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 4'h3, 4'h4, 1'b0, 5'h07};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 4'h1, 4'h1, 1'b0, 5'h02};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'h2, 4'h3, 1'b1, 5'h06};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'hF, 4'hF, 1'b1, 5'h1F};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 4'h7, 4'h1, 1'b0, 5'h08};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4'hF, 4'h1, 1'b0, 5'h10};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00};

        v1_in = 1'b0; a1 = 1'b0; b1 = 1'b0; r1 = 1'b0;
        v4_in = 1'b0; a4 = 4'h0; b4 = 4'h0; r4 = 1'b0;

        #1;
        check("rst_w1", {5'b0, ov1, k1, c1}, 8'h00);
        check("rst_w4", {2'b0, ov4, k4, c4}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].r1, tbl[i].e1,
                  tbl[i].v4, tbl[i].a4, tbl[i].b4, tbl[i].r4, tbl[i].e4);
        end
        idle();

        // Capture 7, then assert reset mid-cycle while a new operation is valid.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h3, 4'h4, 1'b0, 5'h07);
        @(posedge clk);
        #2;
        v4_in = 1'b1; a4 = 4'h5; b4 = 4'h6;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_c", {4'b0, c4}, 8'h00);
        check("async_rst_ripout", {7'b0, k4}, 8'h00);
        check("async_rst_valid", {6'b0, ov4, ov1}, 8'h00);
        check("async_rst_w1", {6'b0, k1, c1}, 8'h00);
        v1_in = 1'b0; v4_in = 1'b0;
        hold1 = '0; hold4 = '0;
        exp1_q.delete(); exp4_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", {6'b0, ov4, ov1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_c", {3'b0, k4, c4}, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h2, 4'h2, 1'b0, 5'h04);
        idle();

        for (int i = 0; i < 16; i++) begin
            logic       ra1, rb1, rr1, rr4;
            logic [3:0] ra4, rb4;
            logic [1:0] s1;
            logic [4:0] s4;
            ra1 = 1'($urandom); rb1 = 1'($urandom); rr1 = 1'($urandom);
            ra4 = 4'($urandom_range(0, 15)); rb4 = 4'($urandom_range(0, 15));
            rr4 = 1'($urandom);
            s1 = {1'b0, ra1} + {1'b0, rb1} + {1'b0, rr1};
            s4 = {1'b0, ra4} + {1'b0, rb4} + {4'b0, rr4};
            if (i % 5 == 4) idle();
            else drive(1'b1, ra1, rb1, rr1, s1, 1'b1, ra4, rb4, rr4, s4);
        end
        idle();
        idle();

        @(posedge clk);
        #2;
        check("queue_drained", 8'(exp1_q.size() + exp4_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_full_adder
